// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, the latency counter width and the address check.
package mem_pkg;

    localparam int CNT_W  = 4;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A byte address is bad when it is not word aligned or lands past the last word.
    function automatic logic addr_error(input logic [ADDR_W-1:0] addr,
                                        input logic [ADDR_W-1:0] entries);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[ADDR_W-1:2]} >= entries);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, registered read.
// Contents start at zero and are never touched by reset.
module dmem_array #(
    parameter int BIT_WIDTH   = 32,
    parameter int ENTRY_COUNT = 32,
    localparam int IDX_W      = $clog2(ENTRY_COUNT)
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [IDX_W-1:0]     idx,
    input  logic [BIT_WIDTH-1:0] wdata,
    output logic [BIT_WIDTH-1:0] rdata
);

    logic [BIT_WIDTH-1:0] mem [ENTRY_COUNT] = '{default: '0};

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: one outstanding request, IDLE -> WAIT -> RESP.
// The array is touched only on the WAIT->RESP edge, so reset in WAIT cancels the access.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int BIT_WIDTH   = 32,
    parameter int ENTRY_COUNT = 32,
    parameter int LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BIT_WIDTH-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    output state_t               dbg_state
);

    localparam int IDX_W = $clog2(ENTRY_COUNT);

    if (LATENCY < 1 || LATENCY > (2**CNT_W) - 1) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..15");
    end

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic                 we_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [BIT_WIDTH-1:0] wdata_q;
    logic                 rsp_valid_q;
    logic                 rsp_err_q;
    logic                 rd_hit_q;
    logic                 err_now;
    logic                 access;
    logic                 arr_en;
    logic [BIT_WIDTH-1:0] arr_rdata;

    assign err_now = addr_error(addr_q, ADDR_W'(ENTRY_COUNT));
    assign access  = (state == WAIT) && (cnt == CNT_W'(1));
    assign arr_en  = access && !rst && !err_now;

    dmem_array #(
        .BIT_WIDTH  (BIT_WIDTH),
        .ENTRY_COUNT(ENTRY_COUNT)
    ) u_array (
        .clk  (clk),
        .en   (arr_en),
        .we   (we_q),
        .idx  (addr_q[IDX_W+1:2]),
        .wdata(wdata_q),
        .rdata(arr_rdata)
    );

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // the request side is ready only in IDLE, the response is held stable in RESP until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_hit_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= CNT_W'(LATENCY);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        cnt         <= '0;
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_now;
                        rd_hit_q    <= !we_q && !err_now;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rd_hit_q    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read data lives in the array's output register; it is only exposed for a good read.
    assign rsp_rdata = rd_hit_q ? arr_rdata : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for function/reset/stall,
// LATENCY=1 instance with rsp_ready tied high for back-to-back throughput.
module tb_dmem_responder;
    import mem_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0]   req_addr;
    logic [W-1:0]  req_wdata, rsp_rdata;
    state_t        dbg_state;

    logic          req_valid1, req_ready1, rsp_valid1, rsp_err1, busy1;
    logic [31:0]   req_addr1;
    logic [W-1:0]  rsp_rdata1;
    state_t        dbg_state1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    dmem_responder #(.BIT_WIDTH(W), .ENTRY_COUNT(32), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .dbg_state(dbg_state)
    );

    dmem_responder #(.BIT_WIDTH(W), .ENTRY_COUNT(32), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_we(1'b0),
        .req_addr(req_addr1), .req_wdata(32'h0), .rsp_valid(rsp_valid1), .rsp_ready(1'b1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .busy(busy1), .dbg_state(dbg_state1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, "_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_err"},   {31'b0, rsp_err}, 32'd0);
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        check({tag, "_busy"},  {31'b0, busy}, 32'd0);
        check({tag, "_state"}, {30'b0, dbg_state}, {30'b0, IDLE});
    endtask

    // Bounded wait for rsp_valid; returns the number of edges taken.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [W-1:0] wdata, input logic [W-1:0] exp_rdata,
                          input logic exp_err, input int stall);
        int lat;
        logic [W-1:0] exp_d;
        exp_q.push_back(exp_rdata);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        rsp_ready = (stall == 0);
        tick();
        req_valid = 1'b0; req_we = ~we; req_addr = addr ^ 32'h4; req_wdata = ~wdata;
        check({tag, "_busy_after_accept"}, {31'b0, busy}, 32'd1);
        check({tag, "_ready_after_accept"}, {31'b0, req_ready}, 32'd0);
        wait_rsp(lat);
        check({tag, "_latency"}, lat, 32'd2);
        exp_d = exp_q.pop_front();
        check({tag, "_rdata"}, rsp_rdata, exp_d);
        check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
        for (int s = 1; s < stall; s++) begin
            if (s == 2) begin
                req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
            end
            tick();
            req_valid = 1'b0;
            check({tag, "_stall_valid"}, {31'b0, rsp_valid}, 32'd1);
            check({tag, "_stall_rdata"}, rsp_rdata, exp_d);
            check({tag, "_stall_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
            check({tag, "_stall_state"}, {30'b0, dbg_state}, {30'b0, RESP});
        end
        rsp_ready = 1'b1;
        tick();
        check_idle({tag, "_after_hs"});
        tick();
        check({tag, "_no_extra_accept"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; req_valid1 = 1'b0; req_addr1 = 32'h10;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");
        check("reset1_ready", {31'b0, req_ready1}, 32'd1);
        check("reset1_valid", {31'b0, rsp_valid1}, 32'd0);

        do_req("wr_8",      1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,         1'b0, 0);
        do_req("rd_8",      1'b0, 32'h0000_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
        do_req("wr_0",      1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'h0,         1'b0, 0);
        do_req("wr_7c",     1'b1, 32'h0000_007C, 32'hCAFE_007C, 32'h0,         1'b0, 0);
        do_req("rd_7c",     1'b0, 32'h0000_007C, 32'h0,         32'hCAFE_007C, 1'b0, 0);
        do_req("rd_misal",  1'b0, 32'h0000_0006, 32'h0,         32'h0,         1'b1, 0);
        do_req("rd_oor",    1'b0, 32'h0000_0080, 32'h0,         32'h0,         1'b1, 0);
        do_req("wr_oor",    1'b1, 32'h0000_0080, 32'hFFFF_FFFF, 32'h0,         1'b1, 0);
        do_req("wr_misal",  1'b1, 32'h0000_0005, 32'h5555_5555, 32'h0,         1'b1, 0);
        do_req("rd_8_stall", 1'b0, 32'h0000_0008, 32'h0,        32'hDEAD_BEEF, 1'b0, 5);
        do_req("rd_0",      1'b0, 32'h0000_0000, 32'h0,         32'h0BAD_F00D, 1'b0, 0);
        do_req("rd_4",      1'b0, 32'h0000_0004, 32'h0,         32'h0,         1'b0, 0);

        // Reset on the first WAIT edge.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4; req_wdata = 32'h1234_5678;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rst_wait_early");

        // Reset on the edge that would perform the write.
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rst_wait_late");
        do_req("rd_4_after_rst", 1'b0, 32'h0000_0004, 32'h0, 32'h0, 1'b0, 0);

        // Reset while a response is pending drops it.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        wait_rsp(lat);
        check("rst_resp_latency", lat, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        check_idle("rst_resp");
        do_req("rd_8_after_rst", 1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

        // LATENCY=1 with request held: accept, WAIT, RESP+handshake, repeat every 3 cycles.
        req_valid1 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check($sformatf("b2b_ready_%0d", k), {31'b0, req_ready1}, {31'b0, (k % 3) == 2});
            check($sformatf("b2b_valid_%0d", k), {31'b0, rsp_valid1}, {31'b0, (k % 3) == 1});
            check($sformatf("b2b_err_%0d", k), {31'b0, rsp_err1}, 32'd0);
            check($sformatf("b2b_rdata_%0d", k), rsp_rdata1, 32'd0);
        end
        req_valid1 = 1'b0;

        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter BIT_WIDTH, default 32, data word width in bits.
REQ-002 Parameter ENTRY_COUNT, default 32, number of storage words.
REQ-003 Parameter LATENCY, default 2, cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  BIT_WIDTH  write data.
REQ-011 rsp_valid  output  1  response is presented.
REQ-012 rsp_ready  input  1  initiator accepts the response.
REQ-013 rsp_rdata  output  BIT_WIDTH  read data; 0 for writes and errors.
REQ-014 rsp_err  output  1  request was misaligned or out of range.
REQ-015 busy  output  1  high in any state except IDLE; drives initiator pipeline stall.

Function
REQ-016 Three-state FSM (IDLE, WAIT, RESP) SHALL control the block; req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-017 Acceptance SHALL occur on a rising edge with req_valid && req_ready; req_we, req_addr and req_wdata SHALL be latched at that edge.
REQ-018 On acceptance, the FSM SHALL move IDLE->WAIT and load a 4-bit down-counter with LATENCY.
REQ-019 In WAIT, the counter SHALL decrement each cycle; on the edge where it equals 1, the FSM SHALL move WAIT->RESP, so rsp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-020 The array access SHALL happen on the WAIT->RESP edge: write stores latched wdata; read captures the word into the rsp_rdata register.
REQ-021 Word index = latched addr[$clog2(ENTRY_COUNT)+1:2]; error if addr[1:0] != 0 or addr[31:2] >= ENTRY_COUNT.
REQ-022 On error: no array write, rsp_rdata = 0, rsp_err = 1; response timing is identical to a legal access.
REQ-023 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL stay stable until rsp_valid && rsp_ready; on that edge the FSM SHALL return to IDLE and clear rsp_err and rsp_rdata.
REQ-024 No overlap: a new request SHALL NOT be accepted in the RESP handshake cycle; peak throughput is one request per LATENCY+2 cycles.
REQ-025 req_valid while not in IDLE SHALL be ignored, with no side effects.
REQ-026 Write to a word followed by a read of the same word SHALL return the new data.

Reset
REQ-027 With rst high at an edge, the FSM SHALL go to IDLE, the counter to 0, and rsp_valid, rsp_err and rsp_rdata to 0; after reset, req_ready = 1 and busy = 0.
REQ-028 Reset during WAIT SHALL abort the request with no array write; reset during RESP SHALL drop the response.
REQ-029 Storage contents SHALL NOT be cleared by reset; the array is initialised to zero at time zero only.
REQ-030 rst SHALL take priority over every simultaneous handshake.

Structure
REQ-031 Package mem_pkg SHALL hold the FSM state enum (IDLE, WAIT, RESP) and the LATENCY counter width constant.
REQ-032 The storage array SHALL be a sub-module dmem_array, with synchronous write and registered read, one port, parameterised by BIT_WIDTH and ENTRY_COUNT.
REQ-033 LATENCY outside 1..15 SHALL cause an elaboration error.

Verification
REQ-034 Reset, then write 0xDEADBEEF to 0x0000_0008, then read 0x0000_0008 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid rises 2 cycles after each acceptance.
REQ-035 LATENCY = 1, back-to-back reads with rsp_ready tied high -> one acceptance every 3 cycles; req_ready low for exactly 2 cycles per request.
REQ-036 Read 0x0000_0006 (misaligned) and read 0x0000_0080 (index 32) -> rsp_err = 1, rsp_rdata = 0; memory word 0 is unchanged.
REQ-037 rsp_ready held low for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable for all 5 cycles; the FSM leaves RESP only on the handshake edge; the pulse on req_valid meanwhile is ignored.
REQ-038 Write 0x12345678 to 0x4, with rst asserted in WAIT -> the following read of 0x4 returns its prior value (0); all outputs are 0 and req_ready = 1 the cycle after reset.
